// File: rtl/div_unit.sv
// Multi-cycle 32-bit integer divider (DIV/DIVU) for the EX stage.
// Restoring shift-subtract, one quotient bit per cycle; results land in HI (remainder) / LO (quotient).
module div_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        annul,
   input  logic        signed_div,
   input  logic [31:0] opdata1,
   input  logic [31:0] opdata2,
   output logic [31:0] result_hi,
   output logic [31:0] result_lo,
   output logic        ready
);

   typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_BUSY, S_DONE} state_t;

   state_t      r_state;
   logic [64:0] r_work;
   logic [31:0] r_divisor;
   logic [5:0]  r_cnt;
   logic        r_sign_a;
   logic        r_sign_b;
   logic        r_signed;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic        r_ready;

   logic [31:0] w_mag_a;
   logic [31:0] w_mag_b;
   logic [64:0] w_shift;
   logic [32:0] w_diff;
   logic [64:0] w_step;
   logic [31:0] w_quot;
   logic [31:0] w_rem;
   logic [31:0] w_quot_fix;
   logic [31:0] w_rem_fix;

   assign w_mag_a = (signed_div && opdata1[31]) ? -opdata1 : opdata1;
   assign w_mag_b = (signed_div && opdata2[31]) ? -opdata2 : opdata2;

   // Remainder stays below the divisor, so bit 64 is always 0 and may shift out.
   assign w_shift = r_work << 1;
   assign w_diff  = w_shift[64:32] - {1'b0, r_divisor};
   assign w_step  = w_diff[32] ? w_shift : {w_diff, w_shift[31:1], 1'b1};
   assign w_quot  = w_step[31:0];
   assign w_rem   = w_step[63:32];

   // Negating 0x80000000 wraps to itself, which gives the MIN/-1 result for free.
   assign w_quot_fix = (r_signed && (r_sign_a ^ r_sign_b)) ? -w_quot : w_quot;
   assign w_rem_fix  = (r_signed && r_sign_a) ? -w_rem : w_rem;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 6'd0;
         r_ready <= 1'b0;
         r_hi    <= 32'd0;
         r_lo    <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start && !annul) begin
                  if (opdata2 == 32'd0) begin
                     r_state <= S_DIVZERO;
                  end else begin
                     r_work    <= {33'd0, w_mag_a};
                     r_divisor <= w_mag_b;
                     r_sign_a  <= opdata1[31];
                     r_sign_b  <= opdata2[31];
                     r_signed  <= signed_div;
                     r_cnt     <= 6'd0;
                     r_state   <= S_BUSY;
                  end
               end
            end
            S_DIVZERO: begin
               if (annul) begin
                  r_state <= S_IDLE;
               end else begin
                  r_state <= S_DONE;
                  r_ready <= 1'b1;
                  r_hi    <= 32'd0;
                  r_lo    <= 32'd0;
               end
            end
            S_BUSY: begin
               if (annul) begin
                  r_state <= S_IDLE;
               end else begin
                  r_work <= w_step;
                  r_cnt  <= r_cnt + 6'd1;
                  if (r_cnt == 6'd31) begin
                     r_state <= S_DONE;
                     r_ready <= 1'b1;
                     r_hi    <= w_rem_fix;
                     r_lo    <= w_quot_fix;
                  end
               end
            end
            S_DONE: begin
               if (!start) begin
                  r_state <= S_IDLE;
                  r_ready <= 1'b0;
                  r_hi    <= 32'd0;
                  r_lo    <= 32'd0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign result_hi = r_hi;
   assign result_lo = r_lo;
   assign ready     = r_ready;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corners plus randomized divides against an arithmetic model.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        annul;
   logic        signed_div;
   logic [31:0] opdata1;
   logic [31:0] opdata2;
   logic [31:0] result_hi;
   logic [31:0] result_lo;
   logic        ready;

   int checks = 0;
   int errors = 0;

   div_unit dut (
      .clk(clk), .rst(rst), .start(start), .annul(annul), .signed_div(signed_div),
      .opdata1(opdata1), .opdata2(opdata2),
      .result_hi(result_hi), .result_lo(result_lo), .ready(ready)
   );

   always #5 clk = ~clk;

   // Reference: plain language-level division; MIN/-1 and /0 handled as explicit rules.
   task automatic model(input bit s, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r);
      logic signed [31:0] sa, sb;
      sa = a; sb = b;
      if (b == 32'd0) begin
         q = 32'd0; r = 32'd0;
      end else if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
         q = 32'h80000000; r = 32'd0;
      end else if (s) begin
         q = sa / sb; r = sa % sb;
      end else begin
         q = a / b; r = a % b;
      end
   endtask

   // Issue one divide, scramble the operands while it runs, check latency/result/hold/clear.
   task automatic run_div(input string name, input bit s, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] eq, er;
      int n, exp_lat;
      bit zero_bad;
      model(s, a, b, eq, er);
      exp_lat = (b == 32'd0) ? 1 : 32;
      @(negedge clk);
      start = 1'b1; signed_div = s; opdata1 = a; opdata2 = b;
      @(negedge clk);
      n = 0; zero_bad = 1'b0;
      while (ready !== 1'b1 && n < 40) begin
         if (result_hi !== 32'd0 || result_lo !== 32'd0) zero_bad = 1'b1;
         opdata1 = $urandom; opdata2 = $urandom; signed_div = $urandom_range(0, 1);
         @(negedge clk);
         n++;
      end
      checks++;
      if (n !== exp_lat) begin
         errors++; $display("FAIL %s latency: got %0d want %0d", name, n, exp_lat);
      end
      checks++;
      if (zero_bad) begin
         errors++; $display("FAIL %s outputs nonzero while not ready", name);
      end
      checks++;
      if (result_lo !== eq || result_hi !== er) begin
         errors++;
         $display("FAIL %s result: lo=%h hi=%h want lo=%h hi=%h", name, result_lo, result_hi, eq, er);
      end
      annul = 1'b1;
      @(negedge clk);
      annul = 1'b0;
      @(negedge clk);
      checks++;
      if (ready !== 1'b1 || result_lo !== eq || result_hi !== er) begin
         errors++;
         $display("FAIL %s hold: ready=%b lo=%h hi=%h want 1 %h %h", name, ready, result_lo, result_hi, eq, er);
      end
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (ready !== 1'b0 || result_lo !== 32'd0 || result_hi !== 32'd0) begin
         errors++;
         $display("FAIL %s clear: ready=%b lo=%h hi=%h want 0 0 0", name, ready, result_lo, result_hi);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b1; annul = 1'b0; signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd0;
      repeat (4) @(negedge clk);
      checks++;
      if (ready !== 1'b0 || result_hi !== 32'd0 || result_lo !== 32'd0) begin
         errors++;
         $display("FAIL reset: ready=%b hi=%h lo=%h want 0 0 0", ready, result_hi, result_lo);
      end
      start = 1'b0; rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_directed;
      run_div("divu_100_7", 1'b0, 32'd100, 32'd7);
      run_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2);
      run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE);
      run_div("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF);
      run_div("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1);
      run_div("divu_small_big", 1'b0, 32'd3, 32'hFFFFFFFF);
   endtask

   task automatic test_divzero;
      run_div("divu_5_0", 1'b0, 32'd5, 32'd0);
      run_div("div_m5_0", 1'b1, 32'hFFFFFFFB, 32'd0);
   endtask

   task automatic test_annul;
      int n;
      bit seen;
      @(negedge clk);
      start = 1'b1; signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7;
      repeat (11) @(negedge clk);
      annul = 1'b1; start = 1'b0;
      @(negedge clk);
      annul = 1'b0;
      seen = 1'b0;
      for (n = 0; n < 40; n++) begin
         if (ready !== 1'b0 || result_lo !== 32'd0) seen = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (seen) begin
         errors++; $display("FAIL annul_busy: ready or result seen after annul, want none");
      end
      run_div("divu_9_3_after_annul", 1'b0, 32'd9, 32'd3);
   endtask

   task automatic test_reset_mid;
      bit seen;
      @(negedge clk);
      start = 1'b1; signed_div = 1'b1; opdata1 = 32'h12345678; opdata2 = 32'd3;
      repeat (21) @(negedge clk);
      rst = 1'b1; annul = 1'b1;
      @(negedge clk);
      rst = 1'b0; annul = 1'b0; start = 1'b0;
      checks++;
      if (ready !== 1'b0 || result_hi !== 32'd0 || result_lo !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid: ready=%b hi=%h lo=%h want 0 0 0", ready, result_hi, result_lo);
      end
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (ready !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++; $display("FAIL reset_mid_after: ready rose after reset, want 0");
      end
      run_div("div_after_reset", 1'b1, 32'hFFFFFF00, 32'd16);
   endtask

   task automatic test_random;
      logic [31:0] a, b;
      for (int i = 0; i < 24; i++) begin
         a = $urandom;
         case (i % 4)
            0: b = $urandom;
            1: b = $urandom_range(1, 100);
            2: b = -$urandom_range(1, 100);
            default: b = (i % 8 == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
         endcase
         run_div($sformatf("rand%0d", i), 1'(i % 2), a, b);
      end
   endtask

   task automatic test_back_to_back;
      run_div("b2b_a", 1'b0, 32'd1000, 32'd10);
      run_div("b2b_b", 1'b1, 32'hFFFFFC18, 32'd10);
   endtask

   initial begin
      test_reset;
      test_directed;
      test_divzero;
      test_annul;
      test_reset_mid;
      test_back_to_back;
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
